// File: rtl/servo_pkg.sv
// Shared constants, state type and clamp helper for the servo command scheduler.
package servo_pkg;

    localparam int unsigned PERIOD_CYCLES = 4000000;
    localparam int unsigned MIN_PULSE     = 200000;
    localparam int unsigned MAX_PULSE     = 400000;
    localparam int unsigned CENTER_PULSE  = 300000;
    localparam int unsigned STEP          = 2000;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    function automatic logic [31:0] clamp_pulse(
        input logic [31:0] pulse,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (pulse < lo)
            return lo;
        else if (pulse > hi)
            return hi;
        else
            return pulse;
    endfunction

endpackage

// File: rtl/servo_pwm_core.sv
// Period counter and glitch-free registered PWM compare.
module servo_pwm_core
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = servo_pkg::PERIOD_CYCLES
) (
    input  logic        clock_clk,
    input  logic        reset_low,
    input  logic [31:0] cur_pulse_next,
    output logic        wrap,
    output logic        period_start,
    output logic        pwm_out
);

    logic [31:0] count;
    logic [31:0] count_next;

    assign wrap         = (count == 32'(PERIOD_CYCLES - 1));
    assign count_next   = wrap ? 32'd0 : count + 32'd1;
    assign period_start = (count == 32'd0);

    // Compare against next-state values so the output lines up with count.
    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            count   <= 32'd0;
            pwm_out <= 1'b0;
        end else begin
            count   <= count_next;
            pwm_out <= (count_next < cur_pulse_next);
        end
    end

endmodule

// File: rtl/servo_cmd_scheduler.sv
// Two-source servo target arbiter with clamp and per-period slew limiting.
module servo_cmd_scheduler
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = servo_pkg::PERIOD_CYCLES,
    parameter int unsigned MIN_PULSE     = servo_pkg::MIN_PULSE,
    parameter int unsigned MAX_PULSE     = servo_pkg::MAX_PULSE,
    parameter int unsigned CENTER_PULSE  = servo_pkg::CENTER_PULSE,
    parameter int unsigned STEP          = servo_pkg::STEP
) (
    input  logic        clock_clk,
    input  logic        reset_low,
    input  logic        req0_valid,
    input  logic [31:0] req0_pulse,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_pulse,
    output logic        req1_ready,
    output logic [31:0] cur_pulse,
    output logic        at_target,
    output logic        grant_id,
    output logic        period_start,
    output logic        pwm_out
);

    state_t      state;
    state_t      state_next;
    logic [31:0] target;
    logic [31:0] target_next;
    logic [31:0] cur_next;
    logic [31:0] diff;
    logic [31:0] step_amt;
    logic        grant_next;
    logic        acc0;
    logic        acc1;
    logic        wrap;

    assign req1_ready = 1'b1;
    assign req0_ready = (state == IDLE) && !req1_valid;
    assign acc1       = req1_valid;
    assign acc0       = req0_valid && req0_ready;
    assign at_target  = (cur_pulse == target);

    assign diff     = (target > cur_pulse) ? target - cur_pulse
                                           : cur_pulse - target;
    assign step_amt = (diff < 32'(STEP)) ? diff : 32'(STEP);

    always_comb begin
        cur_next    = cur_pulse;
        target_next = target;
        grant_next  = grant_id;
        if (wrap && state == RAMP) begin
            if (target > cur_pulse)
                cur_next = cur_pulse + step_amt;
            else
                cur_next = cur_pulse - step_amt;
        end
        // A new target only influences the slew from the following wrap on.
        if (acc1) begin
            target_next = clamp_pulse(req1_pulse, 32'(MIN_PULSE), 32'(MAX_PULSE));
            grant_next  = 1'b1;
        end else if (acc0) begin
            target_next = clamp_pulse(req0_pulse, 32'(MIN_PULSE), 32'(MAX_PULSE));
            grant_next  = 1'b0;
        end
        state_next = (target_next != cur_next) ? RAMP : IDLE;
    end

    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            state     <= IDLE;
            cur_pulse <= 32'(CENTER_PULSE);
            target    <= 32'(CENTER_PULSE);
            grant_id  <= 1'b0;
        end else begin
            state     <= state_next;
            cur_pulse <= cur_next;
            target    <= target_next;
            grant_id  <= grant_next;
        end
    end

    servo_pwm_core #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_pwm (
        .clock_clk     (clock_clk),
        .reset_low     (reset_low),
        .cur_pulse_next(cur_next),
        .wrap          (wrap),
        .period_start  (period_start),
        .pwm_out       (pwm_out)
    );

endmodule

// File: doc/servo_cmd_scheduler.md
# servo_cmd_scheduler

Shares one hobby-servo PWM channel between two command sources: the autonomous navigation path (req0) and the operator/safety override (req1). It arbitrates incoming pulse-width targets, clamps them to the servo's legal range, and slews the active pulse width toward the target one step per PWM period. Pulse-width changes take effect only at period boundaries, so pwm_out never glitches. It sits between the forklift control logic and the physical servo pins.

## Interface
- PERIOD_CYCLES, 4000000: clock cycles per PWM period (20 ms at 200 MHz).
- MIN_PULSE, 200000: minimum legal high time in cycles (1.0 ms).
- MAX_PULSE, 400000: maximum legal high time in cycles (2.0 ms).
- CENTER_PULSE, 300000: high time after reset (1.5 ms).
- STEP, 2000: maximum change of the active pulse width per period.
- clock_clk  in  1  system clock.
- reset_low  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  navigation request valid.
- req0_pulse  in  32  navigation target high time, in cycles.
- req0_ready  out  1  navigation request accepted this cycle when valid.
- req1_valid  in  1  override request valid.
- req1_pulse  in  32  override target high time, in cycles.
- req1_ready  out  1  override request accepted this cycle when valid.
- cur_pulse  out  32  active high time; registered.
- at_target  out  1  cur_pulse equals the latched target.
- grant_id  out  1  source of the last accepted request (0 or 1).
- period_start  out  1  one-cycle pulse on the cycle the period counter is 0.
- pwm_out  out  1  servo PWM drive; registered.

## Operation
- FSM has two states. IDLE: cur_pulse == target. RAMP: cur_pulse != target.
- Handshake: a transfer occurs when valid && ready are both high in the same cycle. ready is combinational:
  - req1_ready = 1 at all times.
  - req0_ready = (state == IDLE) && !req1_valid.
- Priority: req1 always wins. It preempts a ramp in progress and retargets it. req0 is never accepted during RAMP.
- On accept:
  - target <= clamp(pulse, MIN_PULSE, MAX_PULSE), treating pulse as unsigned.
  - grant_id <= source.
  - Next state is RAMP if the clamped value != cur_pulse, otherwise IDLE.
- Period counter runs 0..PERIOD_CYCLES-1 and wraps to 0.
- On the edge where the counter wraps, if in RAMP: cur_pulse moves toward target by min(STEP, |target - cur_pulse|).
  - If cur_pulse then equals target, the FSM enters IDLE on that same edge.
  - The slew direction is recomputed at every wrap, so a mid-ramp reversal needs no special handling.
- pwm_out <= (count_next < cur_pulse_next). This makes pwm_out phase-aligned with the counter, and each new width applies starting with the first cycle of a period.
- at_target = (cur_pulse == target), combinational from registers.

## Timing
- Reset values:
  - count = 0, cur_pulse = target = CENTER_PULSE, state = IDLE.
  - grant_id = 0, pwm_out = 0, at_target = 1, period_start = 1.
- In the first cycle after reset release, pwm_out rises to 1 and count becomes 1.
- Accept at cycle t: target is visible at t+1. cur_pulse changes only at the next wrap edge; latency is between 1 and PERIOD_CYCLES cycles.
- Full ramp takes ceil(|target - cur| / STEP) periods.
- Accept coinciding with a wrap edge: the slew step on that edge uses the old target. The new target affects the following wrap.
- Both valid in IDLE: req1 is accepted and req0 is held off (req0_ready = 0).
- Both valid in RAMP: req1 is accepted. req0 keeps valid asserted and is accepted on the first IDLE cycle without req1_valid.
- reset_low low mid-ramp: all registers return to reset values immediately, and any in-flight request is dropped.
- All width arithmetic is 32-bit unsigned. |diff| is computed by subtracting the smaller value from the larger, so no underflow occurs.

## Structure
- Shared package servo_pkg holds:
  - PERIOD_CYCLES, MIN_PULSE, MAX_PULSE, CENTER_PULSE and STEP defaults.
  - The state enum {IDLE, RAMP}.
- Sub-module servo_pwm_core holds the period counter, the registered compare output and period_start. It takes cur_pulse_next as input and exposes a wrap strobe.
- The top level holds the arbiter, the clamp, the slew logic and the FSM.

## Test plan
- Reset, hold 3 periods, no requests: cur_pulse = 300000; pwm_out high for exactly 300000 cycles per period; at_target = 1.
- req0 = 310000 in IDLE: accepted in 1 cycle; cur_pulse goes 302000, 304000, ..., 310000 over 5 wraps; at_target rises on the 5th wrap edge.
- req1 = 500000: target clamps to 400000. req0 = 50000: target clamps to 200000.
- req0 and req1 valid in the same cycle (330000 and 270000): req1 accepted with grant_id = 1. req0 is accepted after reaching IDLE at 270000, then the ramp goes to 330000.
- req0 = 320000 ramp, then after 2 wraps req1 = 290000: cur_pulse goes 302000, 304000, 302000, ... down to 290000, and no req0 is accepted meanwhile.
- Reset asserted mid-ramp, then released: cur_pulse = 300000, count = 0 and pwm_out = 0 during reset; normal PWM resumes afterwards.
